// File: rtl/seq_gen_1010_tx.sv
// seq_gen_1010_tx: Moore serial pattern transmitter.
// On start it sends `reps` copies of PATTERN, MSB first, one bit per clock.
// It inserts GAP_LEN forced-zero bits between copies, then pulses done for one cycle.
// Optional feature macro: SEQ_GEN_TX_ABORT_EN. It adds an `abort` input that
// ends a burst early.
module seq_gen_1010_tx #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter int                 GAP_LEN = 2,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
`ifdef SEQ_GEN_TX_ABORT_EN
    input  logic             abort,
`endif
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_LEN + 1);
    // A zero-length gap still needs a legal 1-bit counter. GAP is never entered then.
    localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_LEN - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [PAT_LEN-1:0] sr_q,      sr_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;

    // State, shift register and counters; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop sample pre-edge values,
        // so the order of these lines does not matter.
        if (reset) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        // NOTE: every signal gets a default first. Without that, a path that skips an
        // assignment would infer a latch.
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rep_cnt_d = rep_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        rep_cnt_d = reps;
                        sr_d      = PATTERN;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_SHIFT: begin
                sr_d = sr_q << 1;
                if (bit_cnt_q == LAST_BIT) begin
                    // Last bit of this copy is on the line now.
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    bit_cnt_d = '0;
                    if (rep_cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else if (GAP_LEN > 0) begin
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        sr_d = PATTERN;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end

            S_GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    sr_d      = PATTERN;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SEQ_GEN_TX_ABORT_EN
        // Abort drops the burst on this edge. The bit now on the line is the last
        // one sent, and done is not pulsed.
        if (abort && (state_q == S_SHIFT || state_q == S_GAP)) begin
            state_d   = S_IDLE;
            sr_d      = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            rep_cnt_d = '0;
        end
`endif
    end

    // Moore outputs: decoded from registered state and the shift register only.
    assign x_out     = (state_q == S_SHIFT) && sr_q[PAT_LEN-1];
    assign bit_valid = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_gen_1010_tx.sv
// Testbench for seq_gen_1010_tx.
// Instance A uses the default parameters. Instance B has GAP_LEN=0.
// Expected output streams come from a model that lists the output vectors
// {x_out, bit_valid, busy, done} for each cycle after start.
module tb_seq_gen_1010_tx;

    typedef logic [3:0] vec_t;
    typedef vec_t vec_q_t[$];

    localparam int DEF_GAP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [7:0] reps_a, reps_b;
    logic       x_a, v_a, busy_a, done_a;
    logic       x_b, v_b, busy_b, done_b;
`ifdef SEQ_GEN_TX_ABORT_EN
    logic       abort_a, abort_b;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_gen_1010_tx dut_a (
        .clk(clk), .reset(reset), .start(start_a), .reps(reps_a),
`ifdef SEQ_GEN_TX_ABORT_EN
        .abort(abort_a),
`endif
        .x_out(x_a), .bit_valid(v_a), .busy(busy_a), .done(done_a)
    );

    seq_gen_1010_tx #(.GAP_LEN(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .reps(reps_b),
`ifdef SEQ_GEN_TX_ABORT_EN
        .abort(abort_b),
`endif
        .x_out(x_b), .bit_valid(v_b), .busy(busy_b), .done(done_b)
    );

    // Observed output vector {x_out, bit_valid, busy, done} of the selected instance.
    function automatic vec_t obs(input bit sel_b);
        return sel_b ? {x_b, v_b, busy_b, done_b} : {x_a, v_a, busy_a, done_a};
    endfunction

    // Reference model: the output vector for each cycle, starting at T+1.
    // The list is the bit stream, then the done cycle, then one idle cycle.
    function automatic vec_q_t model(input int n, input int gap);
        vec_q_t     q;
        logic [3:0] pat;
        pat = 4'b1010;
        for (int r = 0; r < n; r++) begin
            for (int b = 3; b >= 0; b--) q.push_back({pat[b], 3'b110});
            if (r < n - 1)
                for (int g = 0; g < gap; g++) q.push_back(4'b0110);
        end
        q.push_back(4'b0011);
        q.push_back(4'b0000);
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start with a count for exactly one sampling edge.
    // On return, the bench is sampling cycle T+1.
    task automatic issue(input bit sel_b, input int n);
        if (sel_b) begin start_b = 1'b1; reps_b = 8'(n); end
        else       begin start_a = 1'b1; reps_a = 8'(n); end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        reps_a  = 8'($urandom);
        reps_b  = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (obs(0) !== 4'b0000 || obs(1) !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: a=%b b=%b expected 0000", obs(0), obs(1));
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (obs(0) !== 4'b0000 || obs(1) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: a=%b b=%b expected 0000", k, obs(0), obs(1));
            end
        end
    endtask

    task automatic test_single();
        vec_q_t e = model(1, DEF_GAP);
        issue(0, 1);
        foreach (e[k]) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL single[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            tick();
        end
    endtask

    task automatic test_three_reps();
        vec_q_t     e = model(3, DEF_GAP);
        logic [3:0] win = '0;
        int         fill = 0;
        int         det  = 0;
        issue(0, 3);
        foreach (e[k]) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL three_reps[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            // Non-overlapping 1010 detector fed from the DUT's serial line.
            if (v_a) begin
                win = {win[2:0], x_a};
                fill++;
                if (fill >= 4 && win == 4'b1010) begin
                    det++;
                    fill = 0;
                    win  = '0;
                end
            end
            tick();
        end
        tests_run++;
        if (det !== 3) begin
            tests_failed++;
            $display("FAIL three_reps_detections: got %0d expected 3", det);
        end
    endtask

    task automatic test_zero_reps();
        vec_q_t e = model(0, DEF_GAP);
        issue(0, 0);
        foreach (e[k]) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL zero_reps[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            tick();
        end
    endtask

    task automatic test_gap0();
        vec_q_t e = model(2, 0);
        issue(1, 2);
        foreach (e[k]) begin
            tests_run++;
            if (obs(1) !== e[k]) begin
                tests_failed++;
                $display("FAIL gap0[T+%0d]: got %b expected %b", k + 1, obs(1), e[k]);
            end
            tick();
        end
    endtask

    // start pulses during SHIFT, GAP and DONE must not change the stream or requeue.
    task automatic test_start_ignored();
        vec_q_t e = model(3, DEF_GAP);
        issue(0, 3);
        foreach (e[k]) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL start_ignored[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            start_a = (k == 1 || k == 4 || k == 16);
            reps_a  = 8'($urandom_range(1, 9));
            tick();
            start_a = 1'b0;
        end
        tick();
        tests_run++;
        if (obs(0) !== 4'b0000) begin
            tests_failed++;
            $display("FAIL start_ignored_tail: got %b expected 0000", obs(0));
        end
    endtask

    task automatic test_reset_mid();
        vec_q_t e = model(3, DEF_GAP);
        issue(0, 3);
        for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL reset_mid_pre[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            if (k == 5) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        for (int k = 7; k <= 8; k++) begin
            tests_run++;
            if (obs(0) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_mid_abort[T+%0d]: got %b expected 0000", k, obs(0));
            end
            if (k == 7) tick();
        end
        issue(0, 3);
        foreach (e[k]) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL reset_mid_restart[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            tick();
        end
        // Reset and start together: reset wins.
        reset   = 1'b1;
        start_a = 1'b1;
        reps_a  = 8'd2;
        tick();
        reset   = 1'b0;
        start_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs(0) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_over_start[%0d]: got %b expected 0000", k, obs(0));
            end
            tick();
        end
    endtask

    // Random bursts on both instances. A zero idle gap gives back-to-back starts
    // in the first IDLE cycle.
    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            bit     sel   = 1'($urandom_range(0, 1));
            int     n     = (it == 11) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
            int     idle  = (it % 3 == 0) ? 0 : int'($urandom_range(0, 3));
            vec_q_t e     = model(n, sel ? 0 : DEF_GAP);
            int     bad   = 0;
            vec_t   first_got = '0;
            vec_t   first_exp = '0;
            issue(sel, n);
            foreach (e[k]) begin
                if (obs(sel) !== e[k] && bad == 0) begin
                    first_got = obs(sel);
                    first_exp = e[k];
                    bad = k + 1;
                end
                // The last entry is the first IDLE cycle; the next burst may start here.
                if (k < e.size() - 1) tick();
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL random[%0d] sel=%0d reps=%0d at T+%0d: got %b expected %b",
                         it, sel, n, bad, first_got, first_exp);
            end
            for (int w = 0; w < idle; w++) tick();
        end
        tick();
    endtask

`ifdef SEQ_GEN_TX_ABORT_EN
    task automatic test_abort();
        vec_q_t e = model(2, DEF_GAP);
        issue(0, 2);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (obs(0) !== e[k]) begin
                tests_failed++;
                $display("FAIL abort_pre[T+%0d]: got %b expected %b", k + 1, obs(0), e[k]);
            end
            if (k == 2) abort_a = 1'b1;
            tick();
        end
        abort_a = 1'b0;
        for (int k = 4; k < 12; k++) begin
            tests_run++;
            if (obs(0) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL abort_idle[T+%0d]: got %b expected 0000", k, obs(0));
            end
            tick();
        end
    endtask
`endif

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        reps_a  = '0;
        reps_b  = '0;
`ifdef SEQ_GEN_TX_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        test_reset();
        test_single();
        test_three_reps();
        test_zero_reps();
        test_gap0();
        test_start_ignored();
        test_reset_mid();
        test_random();
`ifdef SEQ_GEN_TX_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
